// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU I/O port: default widths and read FSM encoding.
package cpu_io_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    // Read FSM state encoding; kept as plain constants so older tools and
    // checkers can compare against fixed bit patterns.
    localparam logic [1:0] RD_IDLE = 2'b00;
    localparam logic [1:0] RD_WAIT = 2'b01;
    localparam logic [1:0] RD_ACK  = 2'b10;

    typedef logic [1:0] rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read, wrapping pointers and an occupancy count.
// A push is accepted when not full, or when full and a pop happens in the
// same cycle (the pop frees the slot the push lands in).
module sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next pointer and count values; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/cpu_io_port.sv
// Host-side I/O controller for the CPU: buffers host words for IN instructions
// and captures OUT writes for the host to drain.
module cpu_io_port
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] host_in_data,
    input  logic              host_in_valid,
    output logic              host_in_ready,
    input  logic              cpu_rd_req,
    output logic [DATA_W-1:0] datain,
    output logic              cpu_rd_ack,
    input  logic              cpu_wr_en,
    input  logic [DATA_W-1:0] dataout,
    output logic              cpu_wr_stall,
    output logic [DATA_W-1:0] host_out_data,
    output logic              host_out_valid,
    input  logic              host_out_ready,
    output logic [CNT_W-1:0]  in_count,
    output logic [CNT_W-1:0]  out_count,
    output logic              err_ovf,
    output rd_state_t         dbg_rd_state
);

    // Handshake: a word moves on any edge where its valid and ready are both high.
    // The CPU side uses one-cycle request pulses instead (cpu_rd_req, cpu_wr_en).

    localparam int FC_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] in_rdata;
    logic [FC_W-1:0]   in_cnt;
    logic              in_full;
    logic              in_empty;
    logic              in_push;
    logic              in_pop;

    logic [FC_W-1:0]   out_cnt;
    logic              out_full;
    logic              out_empty;
    logic              out_pop;

    rd_state_t         state_q, state_d;
    logic [DATA_W-1:0] datain_q, datain_d;
    logic              err_q, err_d;

    assign host_in_ready  = ~in_full;
    assign in_push        = host_in_valid & host_in_ready;
    assign host_out_valid = ~out_empty;
    assign out_pop        = host_out_valid & host_out_ready;
    assign cpu_wr_stall   = out_full;
    assign in_count       = CNT_W'(in_cnt);
    assign out_count      = CNT_W'(out_cnt);
    assign datain         = datain_q;
    assign cpu_rd_ack     = (state_q == RD_ACK);
    assign err_ovf        = err_q;
    assign dbg_rd_state   = state_q;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push),
        .wdata (host_in_data),
        .pop   (in_pop),
        .rdata (in_rdata),
        .count (in_cnt),
        .full  (in_full),
        .empty (in_empty)
    );

    // The FIFO itself accepts a write while full only if the host pops in the same cycle.
    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu_wr_en),
        .wdata (dataout),
        .pop   (out_pop),
        .rdata (host_out_data),
        .count (out_cnt),
        .full  (out_full),
        .empty (out_empty)
    );

    // Read FSM: serve an IN request from the input FIFO, waiting if it is empty.
    always_comb begin
        state_d  = state_q;
        datain_d = datain_q;
        in_pop   = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (cpu_rd_req) begin
                    if (!in_empty) begin
                        in_pop   = 1'b1;
                        datain_d = in_rdata;
                        state_d  = RD_ACK;
                    end else begin
                        state_d  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (!in_empty) begin
                    in_pop   = 1'b1;
                    datain_d = in_rdata;
                    state_d  = RD_ACK;
                end
            end
            RD_ACK: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // Sticky overflow: a CPU write into a full FIFO with no simultaneous host pop is lost.
    always_comb begin
        err_d = err_q | (cpu_wr_en & out_full & ~out_pop);
    end

    // FSM, delivered word and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RD_IDLE;
            datain_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            datain_q <= datain_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_cpu_io_port.sv
// Self-checking bench for cpu_io_port: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of both directions.
module tb_cpu_io_port;
    import cpu_io_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] host_in_data;
    logic          host_in_valid;
    logic          host_in_ready;
    logic          cpu_rd_req;
    logic [DW-1:0] datain;
    logic          cpu_rd_ack;
    logic          cpu_wr_en;
    logic [DW-1:0] dataout;
    logic          cpu_wr_stall;
    logic [DW-1:0] host_out_data;
    logic          host_out_valid;
    logic          host_out_ready;
    logic [CW-1:0] in_count;
    logic [CW-1:0] out_count;
    logic          err_ovf;
    rd_state_t     dbg_rd_state;

    int checks   = 0;
    int failures = 0;
    int ack_seen = 0;

    // Reference model: two word queues, a pending-request flag, an ack flag,
    // the last delivered word and the sticky overflow flag.
    logic [DW-1:0] m_in_q[$];
    logic [DW-1:0] m_out_q[$];
    bit            m_wait;
    bit            m_ack;
    logic [DW-1:0] m_datain;
    bit            m_err;

    always #5 clk = ~clk;

    cpu_io_port #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .cpu_rd_req     (cpu_rd_req),
        .datain         (datain),
        .cpu_rd_ack     (cpu_rd_ack),
        .cpu_wr_en      (cpu_wr_en),
        .dataout        (dataout),
        .cpu_wr_stall   (cpu_wr_stall),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .in_count       (in_count),
        .out_count      (out_count),
        .err_ovf        (err_ovf),
        .dbg_rd_state   (dbg_rd_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_q.delete();
        m_out_q.delete();
        m_wait   = 1'b0;
        m_ack    = 1'b0;
        m_datain = '0;
        m_err    = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit serve;
        bit hpop;
        bit accept;
        bit push_in;
        serve   = m_wait || (!m_ack && cpu_rd_req);
        hpop    = host_out_ready && (m_out_q.size() > 0);
        accept  = cpu_wr_en && ((m_out_q.size() < DEPTH) || hpop);
        push_in = host_in_valid && (m_in_q.size() < DEPTH);
        if (cpu_wr_en && !accept) m_err = 1'b1;
        if (hpop) void'(m_out_q.pop_front());
        if (accept) m_out_q.push_back(dataout);
        m_ack = 1'b0;
        if (serve && m_in_q.size() > 0) begin
            m_datain = m_in_q.pop_front();
            m_ack    = 1'b1;
            m_wait   = 1'b0;
        end else if (serve) begin
            m_wait = 1'b1;
        end
        if (push_in) m_in_q.push_back(host_in_data);
    endtask

    task automatic check_outputs();
        logic [1:0] exp_state;
        exp_state = m_ack ? RD_ACK : (m_wait ? RD_WAIT : RD_IDLE);
        chk("in_count",       32'(in_count),       32'(m_in_q.size()));
        chk("out_count",      32'(out_count),      32'(m_out_q.size()));
        chk("host_in_ready",  32'(host_in_ready),  32'(m_in_q.size() < DEPTH));
        chk("host_out_valid", 32'(host_out_valid), 32'(m_out_q.size() > 0));
        chk("cpu_wr_stall",   32'(cpu_wr_stall),   32'(m_out_q.size() == DEPTH));
        chk("cpu_rd_ack",     32'(cpu_rd_ack),     32'(m_ack));
        chk("datain",         32'(datain),         32'(m_datain));
        chk("err_ovf",        32'(err_ovf),        32'(m_err));
        chk("rd_state",       32'(dbg_rd_state),   32'(exp_state));
        if (m_out_q.size() > 0) chk("host_out_data", 32'(host_out_data), 32'(m_out_q[0]));
    endtask

    // One clock: model consumes current inputs, DUT clocks, pulses clear, outputs compared.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        host_in_valid = 1'b0;
        cpu_rd_req    = 1'b0;
        cpu_wr_en     = 1'b0;
        if (cpu_rd_ack) ack_seen++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic host_push(input logic [DW-1:0] v);
        host_in_valid = 1'b1;
        host_in_data  = v;
        cycle();
    endtask

    task automatic cpu_read();
        cpu_rd_req = 1'b1;
        cycle();
    endtask

    task automatic cpu_write(input logic [DW-1:0] v);
        cpu_wr_en = 1'b1;
        dataout   = v;
        cycle();
    endtask

    initial begin
        logic [DW-1:0] last_word;
        rst            = 1'b1;
        host_in_data   = '0;
        host_in_valid  = 1'b0;
        cpu_rd_req     = 1'b0;
        cpu_wr_en      = 1'b0;
        dataout        = '0;
        host_out_ready = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();

        // Basic IN: two words, two requests four cycles apart.
        host_push(16'hA5A5);
        host_push(16'h1234);
        chk("basic_cnt2", 32'(in_count), 32'd2);
        cpu_read();
        chk("basic_ack0", 32'(cpu_rd_ack), 32'd1);
        chk("basic_d0",   32'(datain), 32'hA5A5);
        chk("basic_cnt1", 32'(in_count), 32'd1);
        idle(3);
        cpu_read();
        chk("basic_ack1", 32'(cpu_rd_ack), 32'd1);
        chk("basic_d1",   32'(datain), 32'h1234);
        chk("basic_cnt0", 32'(in_count), 32'd0);
        idle(2);

        // IN on empty FIFO: request parks in WAIT until a word arrives.
        ack_seen = 0;
        cpu_read();
        idle(5);
        chk("empty_wait", 32'(dbg_rd_state), 32'(RD_WAIT));
        host_push(16'h00FF);
        idle(4);
        chk("empty_acks", 32'(ack_seen), 32'd1);
        chk("empty_data", 32'(datain), 32'h00FF);

        // Fill input FIFO, attempt a push while full, then drain across the wrap.
        for (int i = 0; i < DEPTH; i++) host_push(DW'(i));
        chk("full_ready", 32'(host_in_ready), 32'd0);
        chk("full_cnt",   32'(in_count), 32'd8);
        host_push(16'h0099);
        chk("full_hold",  32'(in_count), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            cpu_read();
            chk("wrap_rd_a", 32'(datain), 32'(i));
            idle(1);
        end
        for (int i = 8; i < 12; i++) host_push(DW'(i));
        for (int i = 8; i < 12; i++) begin
            cpu_read();
            chk("wrap_rd_b", 32'(datain), 32'(i));
            idle(1);
        end

        // OUT with backpressure: ninth write overflows.
        host_out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cpu_write(DW'(16'h0100 + i));
            if (i == 7) begin
                chk("ovf_stall", 32'(cpu_wr_stall), 32'd1);
                chk("ovf_noerr", 32'(err_ovf), 32'd0);
            end
        end
        chk("ovf_err", 32'(err_ovf), 32'd1);
        chk("ovf_cnt", 32'(out_count), 32'd8);
        host_out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", 32'(host_out_data), 32'(16'h0100 + i));
            cycle();
        end
        chk("drain_empty", 32'(host_out_valid), 32'd0);
        host_out_ready = 1'b0;

        // Asynchronous reset mid-read with both FIFOs holding 3 words and err_ovf set.
        for (int i = 0; i < 4; i++) host_push(DW'(16'h0011 + i));
        for (int i = 0; i < 3; i++) cpu_write(DW'(16'h0201 + i));
        cpu_read();
        chk("pre_rst_ack", 32'(cpu_rd_ack), 32'd1);
        chk("pre_rst_in",  32'(in_count), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_in_count",  32'(in_count), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_ack",       32'(cpu_rd_ack), 32'd0);
        chk("rst_datain",    32'(datain), 32'd0);
        chk("rst_err",       32'(err_ovf), 32'd0);
        chk("rst_in_ready",  32'(host_in_ready), 32'd1);
        chk("rst_out_valid", 32'(host_out_valid), 32'd0);
        chk("rst_stall",     32'(cpu_wr_stall), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();

        // Write and pop together while full: write accepted, no overflow.
        for (int i = 0; i < DEPTH; i++) cpu_write(DW'(16'h0300 + i));
        chk("sim_full", 32'(out_count), 32'd8);
        host_out_ready = 1'b1;
        cpu_write(16'hBEEF);
        chk("sim_cnt", 32'(out_count), 32'd8);
        chk("sim_err", 32'(err_ovf), 32'd0);
        last_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            last_word = host_out_data;
            cycle();
        end
        chk("sim_last", 32'(last_word), 32'hBEEF);
        chk("sim_empty", 32'(out_count), 32'd0);

        // Random traffic in both directions.
        for (int n = 0; n < 600; n++) begin
            host_in_valid  = ($urandom_range(0, 1) == 1);
            host_in_data   = DW'($urandom);
            cpu_rd_req     = ($urandom_range(0, 3) == 0);
            cpu_wr_en      = ($urandom_range(0, 4) < 2);
            dataout        = DW'($urandom);
            host_out_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
